// File: rtl/scoreboard_pkg.sv
// Shared types and helpers for the multi-channel scoreboard and the DWRR-side blocks.
`ifndef SCOREBOARD_PKG_SV
`define SCOREBOARD_PKG_SV

// Slice channel idx out of a flat bus packed as channel i at [(i+1)*w-1 : i*w].
`define SB_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package scoreboard_pkg;

  // Per-channel tracking state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } sb_state_e;

  // Occupancy/position counters must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Channel index width, never narrower than one bit.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

`endif

// File: rtl/sb_channel_tracker.sv
// One channel of the scoreboard: mirrors FIFO occupancy, captures one magic
// packet on a start-qualified push and flags the cycle that packet is popped.
module sb_channel_tracker
  import scoreboard_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int REARM  = 0,
  parameter int CNTWID = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out,
  output logic             vld,
  output logic             match,
  output logic             done,
  output logic             proto_pulse
);

  localparam logic [CNTWID-1:0] DEPTH_C = CNTWID'(DEPTH);
  localparam logic [CNTWID-1:0] ONE_C   = CNTWID'(1);

  sb_state_e         state_q, state_d;
  logic [CNTWID-1:0] occ_q, occ_d;
  logic [CNTWID-1:0] pos_q, pos_d;
  logic [WIDTH-1:0]  magic_q, magic_d;

  logic pv;
  logic qv;
  logic exit_now;

  // Qualify FIFO events: only pushes into a non-full FIFO and pops from a
  // non-empty FIFO move the counters; the others are protocol violations.
  always_comb begin
    pv          = push & (occ_q < DEPTH_C);
    qv          = pop & (occ_q != '0);
    proto_pulse = (push & (occ_q == DEPTH_C)) | (pop & (occ_q == '0));
    exit_now    = (state_q == ST_TRACK) & qv & (pos_q == ONE_C);
  end

  // Next-state logic: occupancy always counts; the FSM follows the magic packet.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    magic_d = magic_q;
    occ_d   = occ_q + CNTWID'(pv) - CNTWID'(qv);
    unique case (state_q)
      ST_IDLE: begin
        if (start && pv) begin
          state_d = ST_TRACK;
          magic_d = data_in;
          // 1-based position of the new packet once this cycle's pop is applied.
          pos_d   = occ_q - CNTWID'(qv) + ONE_C;
        end
      end
      ST_TRACK: begin
        // A capture request in the exit cycle is dropped; re-arm happens next cycle.
        if (qv) begin
          if (pos_q == ONE_C) begin
            state_d = (REARM != 0) ? ST_IDLE : ST_DONE;
          end else begin
            pos_d = pos_q - ONE_C;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      occ_q   <= '0;
      pos_q   <= '0;
      magic_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      pos_q   <= pos_d;
      magic_q <= magic_d;
    end
  end

  // Outputs: exit strobe, head-vs-magic compare and parked indication.
  always_comb begin
    vld   = exit_now;
    match = (data_out == magic_q);
    done  = (state_q == ST_DONE);
  end

endmodule

// File: rtl/multi_channel_scoreboard.sv
// Passive integrity monitor over NUM_CH FIFO channels: one tracker per
// channel plus the shared pass signal and sticky error reporting.
module multi_channel_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int REARM  = 0,
  parameter int CNTWID = cnt_width(DEPTH),
  parameter int CHWID  = ch_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       push,
  input  logic [NUM_CH-1:0]       pop,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH*WIDTH-1:0] flat_data_in,
  input  logic [NUM_CH*WIDTH-1:0] flat_data_out,
  output logic [NUM_CH-1:0]       data_out_vld,
  output logic [NUM_CH-1:0]       done,
  output logic                    prop_signal,
  output logic                    err,
  output logic [CHWID-1:0]        err_ch,
  output logic                    proto_err
);

  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] proto_pulse;
  logic [NUM_CH-1:0] mismatch;
  logic [CHWID-1:0]  first_mis;

  logic             err_q, err_d;
  logic [CHWID-1:0] err_ch_q, err_ch_d;
  logic             proto_err_q, proto_err_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sb_channel_tracker #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .REARM  (REARM),
      .CNTWID (CNTWID)
    ) u_trk (
      .clk         (clk),
      .rst         (rst),
      .push        (push[i]),
      .pop         (pop[i]),
      .start       (start[i]),
      .data_in     (`SB_SLICE(flat_data_in, i, WIDTH)),
      .data_out    (`SB_SLICE(flat_data_out, i, WIDTH)),
      .vld         (data_out_vld[i]),
      .match       (match[i]),
      .done        (done[i]),
      .proto_pulse (proto_pulse[i])
    );
  end

  // Mismatch detection and lowest-index mismatching channel.
  always_comb begin
    mismatch    = data_out_vld & ~match;
    prop_signal = ~(|mismatch);
    first_mis   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mismatch[i]) begin
        first_mis = CHWID'(i);
      end
    end
  end

  // Sticky flags; err_ch is frozen after the first recorded mismatch.
  always_comb begin
    err_d       = err_q | (|mismatch);
    err_ch_d    = err_ch_q;
    proto_err_d = proto_err_q | (|proto_pulse);
    if (!err_q && (|mismatch)) begin
      err_ch_d = first_mis;
    end
  end

  // Error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q       <= 1'b0;
      err_ch_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      err_q       <= err_d;
      err_ch_q    <= err_ch_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign err       = err_q;
  assign err_ch    = err_ch_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_multi_channel_scoreboard.sv
// Directed bench for multi_channel_scoreboard: one instance parks in DONE,
// a second instance re-arms after each check.
module tb_multi_channel_scoreboard;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Handshake convention: push/pop/start are single-cycle strobes sampled on
  // the rising edge; data_out is the show-ahead head valid whenever pop is high.

  // One-shot instance
  logic [NUM_CH-1:0]       push0, pop0, start0;
  logic [NUM_CH*WIDTH-1:0] din0, dout0;
  logic [NUM_CH-1:0]       vld0, done0;
  logic                    prop0, err0, proto0;
  logic [1:0]              errch0;

  // Re-arming instance
  logic [NUM_CH-1:0]       push1, pop1, start1;
  logic [NUM_CH*WIDTH-1:0] din1, dout1;
  logic [NUM_CH-1:0]       vld1, done1;
  logic                    prop1, err1, proto1;
  logic [1:0]              errch1;

  multi_channel_scoreboard #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(8), .REARM(0)) dut0 (
    .clk(clk), .rst(rst), .push(push0), .pop(pop0), .start(start0),
    .flat_data_in(din0), .flat_data_out(dout0), .data_out_vld(vld0), .done(done0),
    .prop_signal(prop0), .err(err0), .err_ch(errch0), .proto_err(proto0)
  );

  multi_channel_scoreboard #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(8), .REARM(1)) dut1 (
    .clk(clk), .rst(rst), .push(push1), .pop(pop1), .start(start1),
    .flat_data_in(din1), .flat_data_out(dout1), .data_out_vld(vld1), .done(done1),
    .prop_signal(prop1), .err(err1), .err_ch(errch1), .proto_err(proto1)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle(input bit which);
    if (!which) begin push0 = '0; pop0 = '0; start0 = '0; end
    else        begin push1 = '0; pop1 = '0; start1 = '0; end
  endtask

  // Drive one channel's strobes and data; all other strobes of that DUT cleared.
  task automatic drive(input bit which, input int ch, input bit pu, input bit po, input bit st,
                       input logic [7:0] di, input logic [7:0] dq);
    idle(which);
    if (!which) begin
      push0[ch] = pu; pop0[ch] = po; start0[ch] = st;
      din0[ch*WIDTH +: WIDTH] = di; dout0[ch*WIDTH +: WIDTH] = dq;
    end else begin
      push1[ch] = pu; pop1[ch] = po; start1[ch] = st;
      din1[ch*WIDTH +: WIDTH] = di; dout1[ch*WIDTH +: WIDTH] = dq;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle(0); idle(1);
    din0 = '0; dout0 = '0; din1 = '0; dout1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_vld", 32'(vld0), 32'h0);
    check("rst_done", 32'(done0), 32'h0);
    check("rst_prop", 32'(prop0), 32'h1);
    check("rst_err", 32'(err0), 32'h0);
    check("rst_err_ch", 32'(errch0), 32'h0);
    check("rst_proto", 32'(proto0), 32'h0);

    // Ch0 empty: capture 0x5A, two more pushes, idle, three pops
    drive(0, 0, 1, 0, 1, 8'h5A, 8'h00); settle();
    check("t1_cap_vld", 32'(vld0), 32'h0);
    tick();
    drive(0, 0, 1, 0, 0, 8'h5B, 8'h00); tick();
    drive(0, 0, 1, 0, 0, 8'h5C, 8'h00); tick();
    idle(0); tick();
    check("t1_done_pre", 32'(done0[0]), 32'h0);
    drive(0, 0, 0, 1, 0, 8'h00, 8'h5A); settle();
    check("t1_exit_vld", 32'(vld0), 32'h1);
    check("t1_exit_prop", 32'(prop0), 32'h1);
    tick();
    drive(0, 0, 0, 1, 0, 8'h00, 8'h5B); settle();
    check("t1_pop6_vld", 32'(vld0), 32'h0);
    tick();
    drive(0, 0, 0, 1, 0, 8'h00, 8'h5C); settle();
    check("t1_pop7_vld", 32'(vld0), 32'h0);
    tick();
    idle(0);
    check("t1_done", 32'(done0[0]), 32'h1);
    check("t1_err", 32'(err0), 32'h0);

    // Ch2: three preloaded, capture 0x11 fourth, corrupted head on exit
    for (int k = 0; k < 3; k++) begin
      drive(0, 2, 1, 0, 0, 8'(k + 1), 8'h00); tick();
    end
    drive(0, 2, 1, 0, 1, 8'h11, 8'h00); tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 2, 0, 1, 0, 8'h00, 8'(k + 1)); settle();
      check("t2_pre_vld", 32'(vld0), 32'h0);
      tick();
    end
    drive(0, 2, 0, 1, 0, 8'h00, 8'h12); settle();
    check("t2_exit_vld", 32'(vld0), 32'h4);
    check("t2_exit_prop", 32'(prop0), 32'h0);
    tick();
    idle(0);
    check("t2_err", 32'(err0), 32'h1);
    check("t2_err_ch", 32'(errch0), 32'h2);

    // Ch1 occ=2: capture 0x33 with a same-cycle pop, exit on second later pop
    drive(0, 1, 1, 0, 0, 8'h21, 8'h00); tick();
    drive(0, 1, 1, 0, 0, 8'h22, 8'h00); tick();
    drive(0, 1, 1, 1, 1, 8'h33, 8'h21); settle();
    check("t3_cap_vld", 32'(vld0), 32'h0);
    tick();
    drive(0, 1, 0, 1, 0, 8'h00, 8'h22); settle();
    check("t3_pop1_vld", 32'(vld0), 32'h0);
    tick();
    drive(0, 1, 0, 1, 0, 8'h00, 8'h33); settle();
    check("t3_exit_vld", 32'(vld0), 32'h2);
    check("t3_exit_prop", 32'(prop0), 32'h1);
    tick();
    idle(0);
    check("t3_done", 32'(done0[1]), 32'h1);

    // Ch3 full: overflow push sets proto_err and is not counted
    for (int k = 0; k < 8; k++) begin
      drive(0, 3, 1, 0, 0, 8'(8'h30 + k), 8'h00); tick();
    end
    idle(0);
    check("t4_proto_pre", 32'(proto0), 32'h0);
    drive(0, 3, 1, 0, 0, 8'hFF, 8'h00); tick();
    idle(0);
    check("t4_proto_ovf", 32'(proto0), 32'h1);
    drive(0, 0, 0, 1, 0, 8'h00, 8'h00); tick();
    idle(0);
    check("t4_proto_udf", 32'(proto0), 32'h1);
    // occ still 8: one pop, then capture lands at position 8
    drive(0, 3, 0, 1, 0, 8'h00, 8'h30); tick();
    drive(0, 3, 1, 0, 1, 8'h3F, 8'h00); tick();
    for (int k = 1; k < 8; k++) begin
      drive(0, 3, 0, 1, 0, 8'h00, 8'(8'h30 + k)); settle();
      check("t4_pre_vld", 32'(vld0), 32'h0);
      tick();
    end
    drive(0, 3, 0, 1, 0, 8'h00, 8'h3E); settle();
    check("t4_exit_vld", 32'(vld0), 32'h8);
    check("t4_exit_prop", 32'(prop0), 32'h0);
    tick();
    idle(0);
    check("t4_err_ch_kept", 32'(errch0), 32'h2);

    // Reset during TRACK on ch1 (pos=3)
    rst = 1'b1; tick(); rst = 1'b0;
    drive(0, 1, 1, 0, 0, 8'h41, 8'h00); tick();
    drive(0, 1, 1, 0, 0, 8'h42, 8'h00); tick();
    drive(0, 1, 1, 0, 1, 8'h44, 8'h00); tick();
    drive(0, 0, 0, 1, 0, 8'h00, 8'h00); tick();
    idle(0);
    check("t6_proto_set", 32'(proto0), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_vld", 32'(vld0), 32'h0);
    check("t6_done", 32'(done0), 32'h0);
    check("t6_prop", 32'(prop0), 32'h1);
    check("t6_err", 32'(err0), 32'h0);
    check("t6_err_ch", 32'(errch0), 32'h0);
    check("t6_proto", 32'(proto0), 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0, 8'h44, 8'h00); tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 1, 0, 8'h00, 8'h44); settle();
      check("t6_post_vld", 32'(vld0), 32'h0);
      tick();
    end
    idle(0);
    check("t6_post_proto", 32'(proto0), 32'h0);

    // Re-arming instance: underflow pop, then two back-to-back checks on ch0
    check("r_proto_pre", 32'(proto1), 32'h0);
    drive(1, 2, 0, 1, 0, 8'h00, 8'h00); tick();
    idle(1);
    check("r_proto_udf", 32'(proto1), 32'h1);
    drive(1, 0, 1, 0, 1, 8'hA0, 8'h00); tick();
    drive(1, 0, 0, 1, 0, 8'h00, 8'hA0); settle();
    check("r_exit1_vld", 32'(vld1), 32'h1);
    check("r_exit1_prop", 32'(prop1), 32'h1);
    tick();
    idle(1);
    check("r_done1", 32'(done1), 32'h0);
    drive(1, 0, 1, 0, 1, 8'hA1, 8'h00); tick();
    drive(1, 0, 0, 1, 0, 8'h00, 8'hA1); settle();
    check("r_exit2_vld", 32'(vld1), 32'h1);
    check("r_exit2_prop", 32'(prop1), 32'h1);
    tick();
    idle(1);
    check("r_done2", 32'(done1), 32'h0);
    check("r_err", 32'(err1), 32'h0);

    // Re-arming: capture coinciding with exit is dropped
    drive(1, 1, 1, 0, 1, 8'hB0, 8'h00); tick();
    drive(1, 1, 1, 1, 1, 8'hB1, 8'hB0); settle();
    check("r_b_exit_vld", 32'(vld1), 32'h2);
    tick();
    drive(1, 1, 0, 1, 0, 8'h00, 8'hB1); settle();
    check("r_b_nocap_vld", 32'(vld1), 32'h0);
    tick();
    idle(1);
    check("r_b_err", 32'(err1), 32'h0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_channel_scoreboard.md
Name: multi_channel_scoreboard

Overview:
- Passive data-integrity monitor for NUM_CH independent FIFO channels, e.g. the per-requestor FIFOs behind the DWRR arbiter.
- Per channel, it captures one "magic" packet on a start-qualified push and tracks that packet's position through the FIFO. When the packet is popped, the block checks the FIFO head data against the captured value.
- Generalises the single-channel, one-shot scoreboard: all channels are checked, occupancy is tracked independently of capture, optional re-arm, and sticky error and protocol flags.

Parameters:
- NUM_CH, 4, number of monitored channels
- WIDTH, 8, packet width in bits
- DEPTH, 8, FIFO depth per channel
- REARM, 0, 1 = channel returns to IDLE after a check; 0 = channel parks in DONE
- CNTWID, $clog2(DEPTH)+1, width of the occupancy and position counters
- CHWID, $clog2(NUM_CH) (min 1), width of the channel index

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- push  in  NUM_CH  per-channel FIFO push
- pop  in  NUM_CH  per-channel FIFO pop (arbiter grant)
- start  in  NUM_CH  capture request; qualifies a push in the same cycle
- flat_data_in  in  NUM_CH*WIDTH  push data; channel i at [(i+1)*WIDTH-1:i*WIDTH]
- flat_data_out  in  NUM_CH*WIDTH  FIFO head data (show-ahead), same packing
- data_out_vld  out  NUM_CH  combinational: magic packet leaves channel i this cycle
- done  out  NUM_CH  channel i in DONE state (REARM=0 only)
- prop_signal  out  1  combinational: no channel exiting with mismatched data this cycle
- err  out  1  sticky data-mismatch flag
- err_ch  out  CHWID  channel of the first mismatch
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Single clock domain, clk. rst is synchronous and active high; it overrides everything in the cycle it is asserted.
- Reset values: every state is IDLE; occ, pos, magic, err, err_ch and proto_err are 0. Consequently data_out_vld=0, done=0, prop_signal=1.
- Per-channel signal definitions:
  - pv (valid push) = push & (occ<DEPTH)
  - qv (valid pop) = pop & (occ>0)
- Occupancy counter occ: next value = occ + pv - qv. It always counts, in every state.
- proto_err: set when push&(occ==DEPTH) or pop&(occ==0) on any channel. Invalid events are not counted.
- Per-channel FSM:
  - IDLE -> TRACK on start & pv.
    - Capture cycle: magic <= data_in; pos <= occ - qv + 1, i.e. the new packet's 1-based position after this cycle.
    - start without pv does nothing.
  - TRACK:
    - start and push are ignored for capture.
    - On qv: if pos==1, this is the exit. Otherwise pos <= pos-1.
    - On exit: data_out_vld[i]=1 in that cycle; compare data_out[i] with magic. Next state is IDLE if REARM=1, else DONE.
  - DONE: absorbing until rst. done[i]=1. occ keeps counting.
- prop_signal = AND over i of (~data_out_vld[i] | data_out[i]==magic[i]).
- err and err_ch:
  - err sets on the cycle after any mismatching exit.
  - err_ch latches the lowest-index mismatching channel, only on the first error. Later errors never overwrite it.
- Simultaneous events:
  - Capture with a same-cycle pop is handled by the -qv term.
  - In REARM mode, an exit and a new capture on the same channel in the same cycle is not allowed: the capture is ignored and the channel re-arms next cycle.
  - Channels are fully independent.
- Exit latency: exactly pos valid pops after the capture cycle.
- Reset during TRACK aborts tracking. No check occurs and no flag is set.

Decomposition:
- Shared package scoreboard_pkg:
  - state typedef {IDLE, TRACK, DONE}
  - helper function for CNTWID
  - flat-bus slicing macro/function reused by the DWRR-side blocks
- One sub-module, sb_channel_tracker, instantiated per channel by a generate loop. It contains occ, pos, magic, the FSM, vld/match and a local protocol-error pulse.
- The top level holds the packing, the prop_signal reduction, and the sticky err/err_ch/proto_err registers.

Test Plan:
- Ch0 empty: start+push data 0x5A, then 2 further pushes, then pops on cycles 5,6,7 with head 0x5A on the first pop. Required: data_out_vld[0] on the cycle-5 pop only, prop_signal=1, err=0, done[0]=1 afterwards.
- Ch2: 3 packets preloaded; capture 0x11 as the 4th push; 4 pops with the 4th head forced to 0x12. Required: vld[2] with prop_signal=0 on the 4th pop; next cycle err=1, err_ch=2.
- Ch1 occ=2, same cycle start+push 0x33 and pop. Required: pos=2, so exit on the 2nd subsequent pop.
- Ch3 full (occ=8): push. Required: proto_err=1 next cycle, occ stays 8. Ch0 empty: pop. Required: proto_err stays 1, occ stays 0.
- REARM=1: ch0 captures 0xA0, exits, captures 0xA1, exits, both matching. Required: two vld pulses, done[0]=0, err=0.
- Ch1 in TRACK with pos=3: assert rst for 1 cycle. Required: all outputs at reset values next cycle; later pops produce no vld.
